// File: rtl/fa_using_ha.sv
// ---------------------------------------------------------------------------
// fa_using_ha: registered ripple-carry adder built from half-adder cells.
//
// Each bit slice is a full adder made of exactly two half adders and an OR.
// The slices are chained into a WIDTH-bit ripple-carry adder. The result is
// registered: one cycle of latency, one result per cycle. Registers load only
// when in_valid is high and hold otherwise.
//
// Ports:
//   clk       in   1      rising-edge clock
//   rst       in   1      asynchronous active-high reset
//   a, b      in   WIDTH  operands
//   cin       in   1      carry into bit 0
//   in_valid  in   1      operands valid this cycle
//   sum       out  WIDTH  registered sum
//   carry     out  1      registered carry out of the top bit
//   out_valid out  1      sum/carry were loaded by the previous cycle
// ---------------------------------------------------------------------------

// Half-adder cell: s = x ^ y, c = x & y.
module half_adder (
    input  logic x,
    input  logic y,
    output logic s,
    output logic c
);
    assign s = x ^ y;
    assign c = x & y;
endmodule

// One full-adder slice: two half adders plus an OR on the generate terms.
// g1 and g2 can never both be 1, so the OR never loses a carry.
module fa_slice (
    input  logic a,
    input  logic b,
    input  logic ci,
    output logic s,
    output logic co
);
    logic p, g1, g2;

    half_adder u_ha1 (.x(a), .y(b),  .s(p), .c(g1));
    half_adder u_ha2 (.x(p), .y(ci), .s(s), .c(g2));

    assign co = g1 | g2;
endmodule

module fa_using_ha #(
    parameter int WIDTH = 1
) (
    input  logic             clk,
    input  logic             rst,
    input  logic [WIDTH-1:0] a,
    input  logic [WIDTH-1:0] b,
    input  logic             cin,
    input  logic             in_valid,
    output logic [WIDTH-1:0] sum,
    output logic             carry,
    output logic             out_valid
);
    // Carry chain: c_chain[i] is the carry into slice i, c_chain[WIDTH] is
    // the carry out of the whole adder.
    logic [WIDTH:0]   c_chain;
    logic [WIDTH-1:0] sum_c;

    // vld_pipe[0] is the input strobe, vld_pipe[1] the registered strobe.
    logic [1:0]       vld_pipe;

    assign c_chain[0] = cin;
    assign vld_pipe[0] = in_valid;

    for (genvar gi = 0; gi < WIDTH; gi++) begin : g_slice
        fa_slice u_slice (
            .a  (a[gi]),
            .b  (b[gi]),
            .ci (c_chain[gi]),
            .s  (sum_c[gi]),
            .co (c_chain[gi+1])
        );
    end

    // Data registers load only on valid, so X/Z on the operands during
    // invalid cycles never reaches the outputs.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            sum         <= '0;
            carry       <= 1'b0;
            vld_pipe[1] <= 1'b0;
        end else begin
            vld_pipe[1] <= vld_pipe[0];
            if (vld_pipe[0]) begin
                sum   <= sum_c;
                carry <= c_chain[WIDTH];
            end
        end
    end

    assign out_valid = vld_pipe[1];
endmodule

// File: tb/tb_fa_using_ha.sv
// ---------------------------------------------------------------------------
// tb_fa_using_ha: self-checking bench for fa_using_ha at WIDTH = 1, 8 and 16.
// Expected values come from plain integer addition a + b + cin, with a
// one-cycle delay and hold-on-invalid tracked by a few model variables.
// ---------------------------------------------------------------------------
module tb_fa_using_ha;
    logic clk = 1'b0;
    logic rst = 1'b1;

    always #5 clk = ~clk;

    // WIDTH = 1 instance
    logic       a1 = 1'b0, b1 = 1'b0, c1 = 1'b0, v1 = 1'b0;
    logic       s1, co1, ov1;
    // WIDTH = 8 instance
    logic [7:0] a8 = '0, b8 = '0, s8;
    logic       c8 = 1'b0, v8 = 1'b0, co8, ov8;
    // WIDTH = 16 instance
    logic [15:0] a16 = '0, b16 = '0, s16;
    logic        c16 = 1'b0, v16 = 1'b0, co16, ov16;

    fa_using_ha #(.WIDTH(1)) u_dut1 (
        .clk(clk), .rst(rst), .a(a1), .b(b1), .cin(c1), .in_valid(v1),
        .sum(s1), .carry(co1), .out_valid(ov1)
    );
    fa_using_ha #(.WIDTH(8)) u_dut8 (
        .clk(clk), .rst(rst), .a(a8), .b(b8), .cin(c8), .in_valid(v8),
        .sum(s8), .carry(co8), .out_valid(ov8)
    );
    fa_using_ha #(.WIDTH(16)) u_dut16 (
        .clk(clk), .rst(rst), .a(a16), .b(b16), .cin(c16), .in_valid(v16),
        .sum(s16), .carry(co16), .out_valid(ov16)
    );

    int n_chk  = 0;
    int n_fail = 0;

    task automatic chk(input string tag, input logic [63:0] act, input logic [63:0] exp);
        n_chk++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got %0h expected %0h", tag, act, exp);
        end
    endtask

    // Advance to just after the next rising edge.
    task automatic step();
        @(posedge clk);
        #1;
    endtask

    task automatic chk_all_zero(input string tag);
        chk({tag, "_s1"},   64'(s1),   64'd0);
        chk({tag, "_co1"},  64'(co1),  64'd0);
        chk({tag, "_ov1"},  64'(ov1),  64'd0);
        chk({tag, "_s8"},   64'(s8),   64'd0);
        chk({tag, "_co8"},  64'(co8),  64'd0);
        chk({tag, "_ov8"},  64'(ov8),  64'd0);
        chk({tag, "_s16"},  64'(s16),  64'd0);
        chk({tag, "_co16"}, 64'(co16), 64'd0);
        chk({tag, "_ov16"}, 64'(ov16), 64'd0);
    endtask

    task automatic run8(input int a, input int b, input int c, input string tag);
        int tot;
        a8 = 8'(a); b8 = 8'(b); c8 = 1'(c); v8 = 1'b1;
        tot = a + b + c;
        step();
        chk({tag, "_sum"},   64'(s8),  64'(tot % 256));
        chk({tag, "_carry"}, 64'(co8), 64'(tot / 256));
        chk({tag, "_vld"},   64'(ov8), 64'd1);
        v8 = 1'b0;
    endtask

    initial begin
        int tot;
        int exp_s, exp_c, exp_v;
        int ra, rb, rc, rv;

        // Reset asserted from time 0: everything cleared before any capture.
        #2;
        chk_all_zero("rst_init");
        #20;
        @(negedge clk);
        rst = 1'b0;

        // WIDTH=1 exhaustive truth table, back-to-back valid.
        for (int v = 0; v < 8; v++) begin
            a1 = 1'((v >> 2) & 1); b1 = 1'((v >> 1) & 1); c1 = 1'(v & 1); v1 = 1'b1;
            tot = ((v >> 2) & 1) + ((v >> 1) & 1) + (v & 1);
            step();
            chk($sformatf("tt%0d_sum", v),   64'(s1),  64'(tot % 2));
            chk($sformatf("tt%0d_carry", v), 64'(co1), 64'(tot / 2));
            chk($sformatf("tt%0d_vld", v),   64'(ov1), 64'd1);
        end

        // Hold: 1+1+1 then invalid with X on the operands.
        a1 = 1'b1; b1 = 1'b1; c1 = 1'b1; v1 = 1'b1;
        step();
        chk("hold_load_sum", 64'(s1), 64'd1);
        a1 = 1'bx; b1 = 1'bz; c1 = 1'bx; v1 = 1'b0;
        step();
        chk("hold_sum",   64'(s1),  64'd1);
        chk("hold_carry", 64'(co1), 64'd1);
        chk("hold_vld",   64'(ov1), 64'd0);
        step();
        chk("hold2_sum",  64'(s1),  64'd1);

        // Async reset with nonzero outputs pending, checked before any edge.
        a1 = 1'b0; b1 = 1'b0; c1 = 1'b0;
        rst = 1'b1;
        #1;
        chk("rst_async_sum",   64'(s1),  64'd0);
        chk("rst_async_carry", 64'(co1), 64'd0);
        chk("rst_async_vld",   64'(ov1), 64'd0);
        @(negedge clk);
        rst = 1'b0;

        // WIDTH=8 boundaries.
        run8(8'hFF, 8'h00, 1, "w8_ripple");
        run8(8'hFF, 8'hFF, 1, "w8_max");
        run8(8'h00, 8'h00, 0, "w8_zero");
        run8(8'hA5, 8'h5A, 0, "w8_mix");

        // Reset mid-stream: 0x0F+0x01 presented, rst pulsed before the edge.
        a8 = 8'h0F; b8 = 8'h01; c8 = 1'b0; v8 = 1'b1;
        #2;
        rst = 1'b1;
        step();
        chk_all_zero("rst_mid");
        @(negedge clk);
        a8 = 8'h10; b8 = 8'h20; c8 = 1'b0; v8 = 1'b1;
        rst = 1'b0;
        step();
        chk("rst_rel_sum",   64'(s8),  64'h30);
        chk("rst_rel_carry", 64'(co8), 64'd0);
        chk("rst_rel_vld",   64'(ov8), 64'd1);
        v8 = 1'b0;

        // Random WIDTH=16 against arithmetic model with hold-on-invalid.
        exp_s = 0; exp_c = 0; exp_v = 0;
        for (int i = 0; i < 1000; i++) begin
            ra = int'($urandom_range(0, 65535));
            rb = int'($urandom_range(0, 65535));
            rc = int'($urandom_range(0, 1));
            rv = ($urandom_range(0, 9) < 7) ? 1 : 0;
            if (i % 97 == 0) begin ra = 65535; rb = 65535 - rb % 2; end
            a16 = 16'(ra); b16 = 16'(rb); c16 = 1'(rc); v16 = 1'(rv);
            step();
            if (rv == 1) begin
                tot   = ra + rb + rc;
                exp_s = tot % 65536;
                exp_c = tot / 65536;
            end
            exp_v = rv;
            if (s16 !== 16'(exp_s) || co16 !== 1'(exp_c) || ov16 !== 1'(exp_v) || i % 50 == 0) begin
                chk($sformatf("rnd%0d_sum", i),   64'(s16),  64'(exp_s));
                chk($sformatf("rnd%0d_carry", i), 64'(co16), 64'(exp_c));
                chk($sformatf("rnd%0d_vld", i),   64'(ov16), 64'(exp_v));
            end
        end

        $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
        $finish;
    end
endmodule
